// File: rtl/e203_subsys_clint_icb_arbt.sv
// Two-master ICB arbiter in front of the CLINT slave port. An ID FIFO records
// which master issued each accepted command so responses route back in order.
module e203_subsys_clint_icb_arbt #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int ARBT_RR = 1,
   parameter int OUTS_DP = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_icb_cmd_valid,
   output logic            m0_icb_cmd_ready,
   input  logic [AW-1:0]   m0_icb_cmd_addr,
   input  logic            m0_icb_cmd_read,
   input  logic [DW-1:0]   m0_icb_cmd_wdata,
   input  logic [DW/8-1:0] m0_icb_cmd_wmask,
   output logic            m0_icb_rsp_valid,
   input  logic            m0_icb_rsp_ready,
   output logic            m0_icb_rsp_err,
   output logic [DW-1:0]   m0_icb_rsp_rdata,
   input  logic            m1_icb_cmd_valid,
   output logic            m1_icb_cmd_ready,
   input  logic [AW-1:0]   m1_icb_cmd_addr,
   input  logic            m1_icb_cmd_read,
   input  logic [DW-1:0]   m1_icb_cmd_wdata,
   input  logic [DW/8-1:0] m1_icb_cmd_wmask,
   output logic            m1_icb_rsp_valid,
   input  logic            m1_icb_rsp_ready,
   output logic            m1_icb_rsp_err,
   output logic [DW-1:0]   m1_icb_rsp_rdata,
   output logic            s_icb_cmd_valid,
   input  logic            s_icb_cmd_ready,
   output logic [AW-1:0]   s_icb_cmd_addr,
   output logic            s_icb_cmd_read,
   output logic [DW-1:0]   s_icb_cmd_wdata,
   output logic [DW/8-1:0] s_icb_cmd_wmask,
   input  logic            s_icb_rsp_valid,
   output logic            s_icb_rsp_ready,
   input  logic            s_icb_rsp_err,
   input  logic [DW-1:0]   s_icb_rsp_rdata,
   output logic            outs_busy
);
   localparam int PW = (OUTS_DP > 1) ? $clog2(OUTS_DP) : 1;
   localparam int CW = $clog2(OUTS_DP + 1);

   logic [OUTS_DP-1:0] r_fifo;
   logic [PW-1:0]      r_wptr, r_rptr;
   logic [CW-1:0]      r_cnt;
   logic               r_rr;
   logic               r_busy;

   logic          w_full, w_empty, w_any, w_cmd_en, w_gnt, w_head;
   logic          w_push, w_pop;
   logic [CW-1:0] w_cnt_nxt;

   assign w_full  = (r_cnt == CW'(OUTS_DP));
   assign w_empty = (r_cnt == '0);
   assign w_any   = m0_icb_cmd_valid | m1_icb_cmd_valid;
   // rst_n gating keeps cmd_ready low for the whole reset window
   assign w_cmd_en = rst_n & ~w_full & w_any;
   assign w_gnt   = ((ARBT_RR != 0) && m0_icb_cmd_valid && m1_icb_cmd_valid) ? r_rr
                                                                             : ~m0_icb_cmd_valid;
   assign w_head  = r_fifo[r_rptr];

   assign s_icb_cmd_valid  = w_cmd_en;
   assign s_icb_cmd_addr   = w_gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
   assign s_icb_cmd_read   = w_gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
   assign s_icb_cmd_wdata  = w_gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
   assign s_icb_cmd_wmask  = w_gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
   assign m0_icb_cmd_ready = w_cmd_en & ~w_gnt & s_icb_cmd_ready;
   assign m1_icb_cmd_ready = w_cmd_en &  w_gnt & s_icb_cmd_ready;

   assign m0_icb_rsp_valid = ~w_empty & ~w_head & s_icb_rsp_valid;
   assign m1_icb_rsp_valid = ~w_empty &  w_head & s_icb_rsp_valid;
   assign m0_icb_rsp_err   = s_icb_rsp_err;
   assign m1_icb_rsp_err   = s_icb_rsp_err;
   assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
   assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
   assign s_icb_rsp_ready  = ~w_empty & (w_head ? m1_icb_rsp_ready : m0_icb_rsp_ready);

   assign w_push = s_icb_cmd_valid & s_icb_cmd_ready;
   assign w_pop  = s_icb_rsp_valid & s_icb_rsp_ready;

   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_push, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + CW'(1);
         2'b01:   w_cnt_nxt = r_cnt - CW'(1);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   assign outs_busy = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_rr   <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_gnt;
            r_wptr <= (r_wptr == PW'(OUTS_DP - 1)) ? '0 : r_wptr + PW'(1);
            if (ARBT_RR != 0) r_rr <= ~w_gnt;
         end
         if (w_pop)
            r_rptr <= (r_rptr == PW'(OUTS_DP - 1)) ? '0 : r_rptr + PW'(1);
         r_cnt  <= w_cnt_nxt;
         r_busy <= (w_cnt_nxt != '0);
      end
   end
endmodule
